// File: rtl/jtag_tap_oversample.sv
// JTAG TAP controller that oversamples the JTAG pins on the system clock.
// Optional USER data register (ir 5'h10) is built only when JTAG_TAP_USER_DR_EN is defined.
module jtag_tap_oversample #(
    parameter logic [31:0] IDCODE = 32'h249511C3,
    parameter int          IR_LEN = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              jtag_TCK,
    input  logic              jtag_TMS,
    input  logic              jtag_TDI,
    input  logic              jtag_TRSTn,
    output logic              jtag_TDO_data,
    output logic              jtag_TDO_driven,
    output logic [3:0]        tap_state,
    output logic [IR_LEN-1:0] ir,
    output logic [31:0]       user_dr,
    output logic              user_update
);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR,
        UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_t;

    // Pin order {TCK, TMS, TDI, TRSTn}; reset parks the TAP with TMS high and TRSTn asserted.
    localparam logic [3:0] SYNC_RESET = 4'b0100;

    logic [3:0]        sync1_q, sync2_q;
    logic              tck_dly_q;
    logic              tck_s, tms_s, tdi_s, trst_s;
    logic              rise, fall;
    logic              sel_idcode, sel_user;

    tap_state_t        state_q, state_d;
    logic [IR_LEN-1:0] ir_q, ir_d;
    logic [IR_LEN-1:0] ir_sr_q, ir_sr_d;
    logic [31:0]       dr_sr_q, dr_sr_d;
    logic              tdo_q, tdo_d;
    logic              driven_q, driven_d;

    assign {tck_s, tms_s, tdi_s, trst_s} = sync2_q;
    assign rise = tck_s & ~tck_dly_q;
    assign fall = ~tck_s & tck_dly_q;

    assign sel_idcode = (ir_q == IR_LEN'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q   <= SYNC_RESET;
            sync2_q   <= SYNC_RESET;
            tck_dly_q <= 1'b0;
        end else begin
            sync1_q   <= {jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn};
            sync2_q   <= sync1_q;
            tck_dly_q <= tck_s;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        ir_sr_d  = ir_sr_q;
        dr_sr_d  = dr_sr_q;
        tdo_d    = tdo_q;
        driven_d = driven_q;

        if (!trst_s) begin
            state_d = TLR;
            ir_d    = IR_LEN'(1);
        end else if (rise) begin
            unique case (state_q)
                TLR:    state_d = tms_s ? TLR    : RTI;
                RTI:    state_d = tms_s ? SEL_DR : RTI;
                SEL_DR: state_d = tms_s ? SEL_IR : CAP_DR;
                CAP_DR: state_d = tms_s ? EX1_DR : SH_DR;
                SH_DR:  state_d = tms_s ? EX1_DR : SH_DR;
                EX1_DR: state_d = tms_s ? UPD_DR : PAU_DR;
                PAU_DR: state_d = tms_s ? EX2_DR : PAU_DR;
                EX2_DR: state_d = tms_s ? UPD_DR : SH_DR;
                UPD_DR: state_d = tms_s ? SEL_DR : RTI;
                SEL_IR: state_d = tms_s ? TLR    : CAP_IR;
                CAP_IR: state_d = tms_s ? EX1_IR : SH_IR;
                SH_IR:  state_d = tms_s ? EX1_IR : SH_IR;
                EX1_IR: state_d = tms_s ? UPD_IR : PAU_IR;
                PAU_IR: state_d = tms_s ? EX2_IR : PAU_IR;
                EX2_IR: state_d = tms_s ? UPD_IR : SH_IR;
                UPD_IR: state_d = tms_s ? SEL_DR : RTI;
                default: state_d = TLR;
            endcase

            // Register actions belong to the state the TAP is leaving on this rise.
            case (state_q)
                CAP_IR: ir_sr_d = IR_LEN'(1);
                SH_IR:  ir_sr_d = {tdi_s, ir_sr_q[IR_LEN-1:1]};
                UPD_IR: ir_d    = ir_sr_q;
                CAP_DR: dr_sr_d = sel_idcode ? IDCODE : (sel_user ? user_dr : 32'd0);
                SH_DR:  dr_sr_d = (sel_idcode || sel_user) ? {tdi_s, dr_sr_q[31:1]}
                                                           : {31'd0, tdi_s};
                default: ;
            endcase
        end

        if (trst_s && state_q == TLR) begin
            ir_d = IR_LEN'(1);
        end

        if (fall) begin
            tdo_d    = (state_q == SH_IR) ? ir_sr_q[0] : dr_sr_q[0];
            driven_d = (state_q == SH_IR) || (state_q == SH_DR);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= TLR;
            ir_q     <= IR_LEN'(1);
            ir_sr_q  <= '0;
            dr_sr_q  <= '0;
            tdo_q    <= 1'b0;
            driven_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            ir_sr_q  <= ir_sr_d;
            dr_sr_q  <= dr_sr_d;
            tdo_q    <= tdo_d;
            driven_q <= driven_d;
        end
    end

`ifdef JTAG_TAP_USER_DR_EN
    logic [31:0] user_dr_q, user_dr_d;
    logic        user_update_q, user_update_d;

    assign sel_user = (ir_q == IR_LEN'(5'h10));

    always_comb begin
        user_dr_d     = user_dr_q;
        user_update_d = 1'b0;
        if (trst_s && rise && state_q == UPD_DR && sel_user) begin
            user_dr_d     = dr_sr_q;
            user_update_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            user_dr_q     <= '0;
            user_update_q <= 1'b0;
        end else begin
            user_dr_q     <= user_dr_d;
            user_update_q <= user_update_d;
        end
    end

    assign user_dr     = user_dr_q;
    assign user_update = user_update_q;
`else
    assign sel_user    = 1'b0;
    assign user_dr     = 32'd0;
    assign user_update = 1'b0;
`endif

    assign jtag_TDO_data   = tdo_q;
    assign jtag_TDO_driven = driven_q;
    assign tap_state       = state_q;
    assign ir              = ir_q;

endmodule
